// File: rtl/replica_pkg.sv
// Shared types for one replica of the 2-opt annealer: move encoding,
// city count and ordinal address/data width.
package replica_pkg;

  localparam int city_num = 8;
  localparam int city_log = $clog2(city_num + 2);

  // Move kind produced by the move generator
  typedef enum logic {
    TWO = 1'b0,
    THR = 1'b1
  } com_t;

  // One candidate move; K < L for a well-formed 2-opt move
  typedef struct packed {
    com_t                com;
    logic [city_log-1:0] base_id;
    logic [city_log-1:0] K;
    logic [city_log-1:0] L;
  } opt_t;

endpackage

// File: rtl/two_opt_exec.sv
// two_opt_exec: applies an accepted 2-opt move to the replica's ordinal RAM
// by reversing ordinal[K..L] in place, one pairwise swap every four cycles
// through a synchronous 1R/1W port. Rejected moves, non-2-opt moves and
// K>=L finish in one cycle without touching the RAM.
// Optional build macro TWO_OPT_STAT_EN adds a 32-bit applied-move counter.
module two_opt_exec
  import replica_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run_i,
  input  logic                accept,
  input  opt_t                opt,
  output logic                busy,
  output logic                done,
  output logic [city_log-1:0] rd_addr,
  input  logic [city_log-1:0] rd_data,
  output logic                we,
  output logic [city_log-1:0] wr_addr,
  output logic [city_log-1:0] wr_data
`ifdef TWO_OPT_STAT_EN
  ,
  output logic [31:0]         accept_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_I,
    S_RD_J,
    S_WR_I,
    S_WR_J,
    S_DONE
  } state_t;

  state_t              state;
  logic [city_log-1:0] idx_i;
  logic [city_log-1:0] idx_j;
  logic [city_log-1:0] data_i;
  logic [city_log-1:0] wr_data_q;
  logic                wr_from_rd;
  logic [city_log-1:0] next_i;
  logic [city_log-1:0] next_j;
  logic                unused_base_id;

  // base_id identifies the replica upstream; this stage has no use for it
  assign unused_base_id = ^opt.base_id;

  assign next_i = idx_i + city_log'(1);
  assign next_j = idx_j - city_log'(1);

  // ram[j] arrives on rd_data during the first write cycle, so it is passed straight through
  assign wr_data = wr_from_rd ? rd_data : wr_data_q;

  // Swap sequencer: read i, read j, write ram[j] to i, write ram[i] to j, step inward
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      we         <= 1'b0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      wr_data_q  <= '0;
      wr_from_rd <= 1'b0;
      idx_i      <= '0;
      idx_j      <= '0;
      data_i     <= '0;
`ifdef TWO_OPT_STAT_EN
      accept_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run_i) begin
            if (opt.com == TWO && accept && opt.K < opt.L) begin
              idx_i   <= opt.K;
              idx_j   <= opt.L;
              rd_addr <= opt.K;
              busy    <= 1'b1;
              state   <= S_RD_I;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
`ifdef TWO_OPT_STAT_EN
              if (opt.com == TWO && accept) begin
                accept_cnt <= accept_cnt + 32'd1;
              end
`endif
            end
          end
        end
        S_RD_I: begin
          rd_addr <= idx_j;
          state   <= S_RD_J;
        end
        S_RD_J: begin
          data_i     <= rd_data;
          we         <= 1'b1;
          wr_addr    <= idx_i;
          wr_from_rd <= 1'b1;
          state      <= S_WR_I;
        end
        S_WR_I: begin
          wr_from_rd <= 1'b0;
          wr_data_q  <= data_i;
          wr_addr    <= idx_j;
          we         <= 1'b1;
          state      <= S_WR_J;
        end
        S_WR_J: begin
          we    <= 1'b0;
          idx_i <= next_i;
          idx_j <= next_j;
          if (next_i < next_j) begin
            rd_addr <= next_i;
            state   <= S_RD_I;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
`ifdef TWO_OPT_STAT_EN
            accept_cnt <= accept_cnt + 32'd1;
`endif
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_opt_exec.sv
// Testbench for two_opt_exec: drives directed and random moves against an
// external ordinal RAM and checks the RAM contents, done latency, write
// count and busy/done behaviour against a reversal model of the tour.
module tb_two_opt_exec;
  import replica_pkg::*;

  logic                clk;
  logic                reset;
  logic                run_i;
  logic                accept;
  opt_t                opt;
  logic                busy;
  logic                done;
  logic [city_log-1:0] rd_addr;
  logic [city_log-1:0] rd_data;
  logic                we;
  logic [city_log-1:0] wr_addr;
  logic [city_log-1:0] wr_data;
`ifdef TWO_OPT_STAT_EN
  logic [31:0]         accept_cnt;
`endif

  logic                init_req;
  logic [city_log-1:0] ram [0:city_num+1];
  int                  model [0:city_num+1];
  int                  model_cnt;
  int                  n_checks;
  int                  n_fail;

  two_opt_exec dut (
    .clk     (clk),
    .reset   (reset),
    .run_i   (run_i),
    .accept  (accept),
    .opt     (opt),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`ifdef TWO_OPT_STAT_EN
    ,
    .accept_cnt (accept_cnt)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ordinal RAM: synchronous read, synchronous write, bulk identity load on request
  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a <= city_num + 1; a++) ram[a] <= city_log'(a);
    end else if (we) begin
      ram[wr_addr] <= wr_data;
    end
    rd_data <= ram[rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkRam(input string tag);
    for (int a = 0; a <= city_num + 1; a++) begin
      checkOutput($sformatf("%s_ord%0d", tag, a), 32'(ram[a]), 32'(model[a]));
    end
  endtask

  task automatic reinitRam();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    for (int a = 0; a <= city_num + 1; a++) model[a] = a;
  endtask

  // One move; inject_at>0 pulses a second move mid-flight, reset_at>0 resets mid-flight
  task automatic applyStimulus(input string tag, input com_t c, input int k, input int l,
                               input bit acc, input int inject_at, input int reset_at);
    int  n;
    int  writes;
    int  swaps;
    int  exp_lat;
    bit  applied;
    bit  go;
    bit  seen;
    bit  aborted;
    int  tmp;
    applied = (c == TWO) && acc;
    go      = applied && (k < l);
    swaps   = go ? (l - k + 1) / 2 : 0;
    exp_lat = go ? 4 * swaps + 1 : 1;
    @(negedge clk);
    run_i      = 1'b1;
    accept     = acc;
    opt.com    = c;
    opt.base_id = city_log'($urandom_range(0, city_num));
    opt.K      = city_log'(k);
    opt.L      = city_log'(l);
    n = 0; writes = 0; seen = 1'b0; aborted = 1'b0;
    while (!seen && !aborted && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      run_i = 1'b0;
      if (n == inject_at) begin
        run_i   = 1'b1;
        accept  = 1'b1;
        opt.com = TWO;
        opt.K   = city_log'(1);
        opt.L   = city_log'(2);
      end
      if (n == reset_at) begin
        reset = 1'b0;
        #1;
        checkOutput({tag, "_rst_we"}, 32'(we), 32'd0);
        checkOutput({tag, "_rst_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_rst_done"}, 32'(done), 32'd0);
`ifdef TWO_OPT_STAT_EN
        checkOutput({tag, "_rst_cnt"}, accept_cnt, 32'd0);
        model_cnt = 0;
`endif
        #1;
        reset   = 1'b1;
        aborted = 1'b1;
      end else begin
        if (we) writes++;
        if (done) seen = 1'b1;
        else if (go) checkOutput({tag, "_busy_inflight"}, 32'(busy), 32'd1);
      end
    end
    run_i = 1'b0;
    if (aborted) return;
    checkOutput({tag, "_latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_writes"}, 32'(writes), 32'(2 * swaps));
    if (go) begin
      for (int a = 0; a < swaps; a++) begin
        tmp            = model[k + a];
        model[k + a]   = model[l - a];
        model[l - a]   = tmp;
      end
    end
    if (applied) model_cnt++;
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkRam(tag);
`ifdef TWO_OPT_STAT_EN
    checkOutput({tag, "_accept_cnt"}, accept_cnt, 32'(model_cnt));
`endif
  endtask

  initial begin
    int   k;
    int   l;
    com_t c;
    bit   acc;
    n_checks  = 0;
    n_fail    = 0;
    model_cnt = 0;
    reset     = 1'b0;
    init_req  = 1'b1;
    run_i     = 1'b0;
    accept    = 1'b0;
    opt       = '0;
    for (int a = 0; a <= city_num + 1; a++) model[a] = a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
`ifdef TWO_OPT_STAT_EN
    checkOutput("reset_accept_cnt", accept_cnt, 32'd0);
`endif
    init_req = 1'b0;
    reset    = 1'b1;

    $display("[TB] directed moves");
    applyStimulus("k2l7", TWO, 2, 7, 1'b1, 0, 0);
    checkOutput("k2l7_ord2", 32'(model[2]), 32'd7);
    reinitRam();
    applyStimulus("k3l6", TWO, 3, 6, 1'b1, 0, 0);
    reinitRam();
    applyStimulus("k1l8", TWO, 1, 8, 1'b1, 0, 0);
    applyStimulus("k4l4", TWO, 4, 4, 1'b1, 0, 0);
    applyStimulus("reject", TWO, 2, 7, 1'b0, 0, 0);
    applyStimulus("thr", THR, 2, 7, 1'b1, 0, 0);
    reinitRam();
    applyStimulus("inject", TWO, 2, 7, 1'b1, 2, 0);

    $display("[TB] reset mid-move");
    applyStimulus("midrst", TWO, 1, 8, 1'b1, 0, 5);
    reinitRam();
    applyStimulus("after_rst", TWO, 2, 7, 1'b1, 0, 0);

    $display("[TB] random moves");
    for (int r = 0; r < 10; r++) begin
      k   = $urandom_range(1, city_num);
      l   = $urandom_range(k, city_num);
      c   = ($urandom_range(0, 3) == 0) ? THR : TWO;
      acc = ($urandom_range(0, 3) != 0);
      applyStimulus($sformatf("rnd%0d", r), c, k, l, acc, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
